// File: rtl/sequence_generator.sv
// Serial pattern generator: emits pattern MSB-first over pat_len cycles,
// optionally repeated with idle gaps between repetitions; all outputs registered.
module sequence_generator #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int RPT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [RPT_W-1:0]   repeat_cnt,
  input  logic [RPT_W-1:0]   gap,
  output logic               data_out,
  output logic               data_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [LEN_W-1:0]   MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
  localparam logic [RPT_W-1:0]   RPT_ONE   = RPT_W'(1);
  localparam logic [MAX_LEN-1:0] BIT0      = MAX_LEN'(1);

  state_t             state, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d, len_clamp;
  logic [RPT_W-1:0]   rpt_q, rpt_d, gap_q, gap_d, gcnt_q, gcnt_d;
  logic               dout_d, valid_d, busy_d, done_d;

  always_comb begin
    state_d = state;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rpt_d   = rpt_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    len_clamp = (pat_len > MAX_LEN_C) ? MAX_LEN_C : pat_len;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (len_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            pat_d   = pattern;
            len_d   = len_clamp;
            rpt_d   = repeat_cnt;
            gap_d   = gap;
            idx_d   = len_clamp - LEN_ONE;
            state_d = SEND;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q != '0) begin
          idx_d   = idx_q - LEN_ONE;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (rpt_q != '0) begin
          rpt_d = rpt_q - RPT_ONE;
          if (gap_q != '0) begin
            // gcnt counts remaining gap cycles after this one
            state_d = GAP;
            gcnt_d  = gap_q - RPT_ONE;
            busy_d  = 1'b1;
          end else begin
            idx_d   = len_q - LEN_ONE;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - RPT_ONE;
          busy_d = 1'b1;
        end else begin
          state_d = SEND;
          idx_d   = len_q - LEN_ONE;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bit presented next cycle is selected from the next-cycle index.
    dout_d = valid_d & (|(pat_d & (BIT0 << idx_d)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rpt_q      <= '0;
      gap_q      <= '0;
      gcnt_q     <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rpt_q      <= rpt_d;
      gap_q      <= gap_d;
      gcnt_q     <= gcnt_d;
      data_out   <= dout_d;
      data_valid <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: stream-level reference model compared every
// cycle, plus directed scenarios with hand-computed traces.
module tb_sequence_generator;

  logic        clk, reset, start, abort;
  logic [15:0] pattern;
  logic [4:0]  pat_len;
  logic [3:0]  repeat_cnt, gap;
  logic        data_out, data_valid, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  sequence_generator #(.MAX_LEN(16), .LEN_W(5), .RPT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .pat_len(pat_len), .repeat_cnt(repeat_cnt), .gap(gap),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic d; logic v; logic b; logic dn;} obs_t;

  function automatic obs_t mk(logic d, logic v, logic b, logic dn);
    return {d, v, b, dn};
  endfunction

  // Model: on an accepted start, the whole expected output stream is laid out
  // in a queue; each later cycle pops one entry unless aborted.
  obs_t exp_o = '0;
  obs_t q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      exp_o = '0;
    end else if (exp_o.b) begin
      if (abort || q.size() == 0) begin
        q.delete();
        exp_o = '0;
      end else begin
        exp_o = q.pop_front();
      end
    end else begin
      q.delete();
      exp_o = '0;
      if (start && !abort) begin
        int len, rc, gp;
        logic [15:0] pw;
        len = (int'(pat_len) > 16) ? 16 : int'(pat_len);
        rc  = int'(repeat_cnt);
        gp  = int'(gap);
        if (len > 0) begin
          for (int r = 0; r <= rc; r++) begin
            for (int i = len - 1; i >= 0; i--) begin
              pw = pattern >> i;
              q.push_back(mk(pw[0], 1'b1, 1'b1, 1'b0));
            end
            if (r < rc)
              for (int g = 0; g < gp; g++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
          end
        end
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
        exp_o = q.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    n_total++;
    if ({data_out, data_valid, busy, done} !== exp_o)
      $display("FAIL cycle_compare t=%0t: got d/v/b/done=%b required %b",
               $time, {data_out, data_valid, busy, done}, exp_o);
    else
      n_pass++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  // Issues one start, records every cycle until busy drops, compares traces
  // (first cycle in the MSB of each vector) with literals.
  task automatic directed(input string nm, input logic [15:0] p, input logic [4:0] l,
                          input logic [3:0] r, input logic [3:0] g, input bit poke,
                          input int abort_at, input int exp_n, input logic [31:0] ed,
                          input logic [31:0] ev, input logic [31:0] edn);
    logic [31:0] dv, vv, dnv, mdv, mvv;
    int nrec;
    bit fin;
    dv = '0; vv = '0; dnv = '0; mdv = '0; mvv = '0; nrec = 0; fin = 0;
    @(negedge clk);
    pattern = p; pat_len = l; repeat_cnt = r; gap = g; start = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      nrec++;
      dv  = {dv[30:0], data_out};
      vv  = {vv[30:0], data_valid};
      dnv = {dnv[30:0], done};
      mdv = {mdv[30:0], exp_o.d};
      mvv = {mvv[30:0], exp_o.v};
      if (!busy) begin
        fin = 1;
        break;
      end
      pattern    = 16'($urandom);
      pat_len    = 5'($urandom);
      repeat_cnt = 4'($urandom);
      gap        = 4'($urandom);
      abort      = (nrec == abort_at);
      start      = (nrec == abort_at) || (poke && $urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    check({nm, "_finished"}, 32'(fin), 32'd1);
    check({nm, "_len"}, 32'(nrec), 32'(exp_n));
    check({nm, "_data"}, dv, ed);
    check({nm, "_valid"}, vv, ev);
    check({nm, "_done"}, dnv, edn);
    check({nm, "_model_data"}, mdv, ed);
    check({nm, "_model_valid"}, mvv, ev);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; pat_len = '0; repeat_cnt = '0; gap = '0;
    #1;
    check("reset_state", 32'({data_out, data_valid, busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    directed("single", 16'h002A, 5'd6, 4'd0, 4'd0, 1'b0, 0, 7,
             32'b1010100, 32'b1111110, 32'b0000001);
    directed("rep_gap2", 16'h0005, 5'd3, 4'd2, 4'd2, 1'b0, 0, 14,
             32'b10100101001010, 32'b11100111001110, 32'b00000000000001);
    directed("rep_gap0", 16'h0005, 5'd3, 4'd2, 4'd0, 1'b0, 0, 10,
             32'b1011011010, 32'b1111111110, 32'b0000000001);
    directed("abort4", 16'h00B4, 5'd8, 4'd0, 4'd0, 1'b0, 4, 5,
             32'b10110, 32'b11110, 32'b00000);
    directed("busy_starts", 16'h00C3, 5'd8, 4'd1, 4'd1, 1'b1, 0, 18,
             32'b110000110110000110, 32'b111111110111111110, 32'b000000000000000001);
    directed("len0", 16'hFFFF, 5'd0, 4'd3, 4'd2, 1'b0, 0, 1,
             32'b0, 32'b0, 32'b1);
    directed("len20", 16'hA5C3, 5'd20, 4'd0, 4'd0, 1'b0, 0, 17,
             32'b10100101110000110, 32'h0001FFFE, 32'b1);

    // Asynchronous reset between edges in the middle of an emission.
    @(negedge clk);
    pattern = 16'hFF00; pat_len = 5'd16; repeat_cnt = 4'd0; gap = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset", 32'({data_out, data_valid, busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    directed("after_reset", 16'h0039, 5'd6, 4'd0, 4'd0, 1'b0, 0, 7,
             32'b1110010, 32'b1111110, 32'b0000001);

    // Randomized phase, including starts in done cycles, aborts and resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset      = 1'b1;
      start      = ($urandom_range(0, 2) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      pattern    = 16'($urandom);
      pat_len    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31))
                                               : 5'($urandom_range(0, 16));
      repeat_cnt = 4'($urandom_range(0, 4));
      gap        = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) #2 reset = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (200) @(negedge clk);
    check("drained_idle", 32'({busy, data_valid}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter MAX_LEN, default 16, maximum pattern length in bits.
REQ-002 Parameter LEN_W, default 5, width of pat_len; SHALL satisfy 2^LEN_W > MAX_LEN.
REQ-003 Parameter RPT_W, default 4, width of repeat_cnt and gap.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request to emit a sequence; sampled only when idle.
REQ-007 abort  in  1  synchronous cancel of an emission in progress.
REQ-008 pattern  in  MAX_LEN  bit sequence to emit, latched on accepted start.
REQ-009 pat_len  in  LEN_W  number of pattern bits to emit, latched on accepted start.
REQ-010 repeat_cnt  in  RPT_W  extra repetitions; total emissions = repeat_cnt+1, latched on accepted start.
REQ-011 gap  in  RPT_W  idle cycles between repetitions, latched on accepted start.
REQ-012 data_out  out  1  serial bit stream, drives a sequence detector's data_in.
REQ-013 data_valid  out  1  high when data_out carries a pattern bit.
REQ-014 busy  out  1  high while a start has been accepted and emission is not finished.
REQ-015 done  out  1  one-cycle pulse on normal completion.

Function
REQ-016 FSM states SHALL be IDLE, SEND, GAP; all outputs SHALL be registered.
REQ-017 In IDLE, start=1 at edge k SHALL latch all inputs, enter SEND, and present the first bit on data_out with data_valid=1 and busy=1 in cycle k+1.
REQ-018 Bit order SHALL be MSB-first within the length: first bit pattern[pat_len-1], last bit pattern[0].
REQ-019 SEND SHALL emit exactly one bit per cycle for pat_len consecutive cycles.
REQ-020 pat_len > MAX_LEN SHALL be clamped to MAX_LEN at latch time.
REQ-021 pat_len = 0 on accepted start: no bits emitted, data_valid stays 0, busy=0, done=1 in cycle k+1.
REQ-022 After the last bit of a repetition with repetitions remaining: gap>0 -> GAP for exactly gap cycles with data_out=0, data_valid=0, busy=1, then SEND restarting at pattern[pat_len-1]; gap=0 -> next repetition's first bit in the immediately following cycle.
REQ-023 After the last bit of the final repetition: IDLE, data_valid=0, data_out=0, busy=0, done=1 for exactly one cycle.
REQ-024 start in the done cycle SHALL be accepted (state is IDLE); done and the new first bit are then one cycle apart.
REQ-025 start while busy=1 SHALL be ignored; latched inputs SHALL NOT change mid-emission.
REQ-026 abort=1 at any edge while busy SHALL return to IDLE at that edge: data_out=0, data_valid=0, busy=0, done stays 0.
REQ-027 abort and start at the same edge in IDLE: abort wins, start ignored.
REQ-028 Outside SEND, data_out SHALL be 0.
REQ-029 Internal bit index SHALL count down from pat_len-1 to 0; repetition counter counts down from repeat_cnt to 0; neither SHALL wrap.

Reset
REQ-030 reset=0 SHALL immediately, independent of clk, force IDLE, data_out=0, data_valid=0, busy=0, done=0, clear all counters and latched inputs.
REQ-031 reset asserted mid-emission SHALL abandon the sequence with no done pulse; after release the block SHALL wait for a new start.

Verification
REQ-032 pattern=0x002A, pat_len=6, repeat_cnt=0, start pulse -> data_out 1,0,1,0,1,0 with data_valid=1 for 6 cycles, then done=1 one cycle, busy=0.
REQ-033 pattern=0x0005, pat_len=3, repeat_cnt=2, gap=2 -> 101,00,101,00,101 on data_out; data_valid pattern 111,00,111,00,111; single done after last bit.
REQ-034 Same as REQ-033 with gap=0 -> 101101101 over 9 consecutive valid cycles, then done.
REQ-035 pat_len=8, abort=1 on the 4th SEND cycle -> data_valid=0 and busy=0 next cycle, no done; start at that edge also high is ignored.
REQ-036 start pulses while busy, pat_len=0 start, pat_len=20 start -> ignored / immediate done with no valid / 16 bits emitted respectively.
REQ-037 reset=0 asserted between clock edges during SEND -> all outputs 0 before next edge; new start after release emits full pattern from first bit.
